// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front-end and the pipeline
// core that consumes its output.
//   - fetchState_t : fetch sequencer states
//   - DEF_*        : default widths and FIFO depth
//   - OP_*         : opcode field values in bits [7:6] of an instruction
//   - countWidth   : width of a 0..depth occupancy counter
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_PC_W   = 8;
  localparam int DEF_INST_W = 8;
  localparam int DEF_LEN_W  = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // A counter that must hold the value 'depth' itself needs one extra bit.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of DEPTH entries x WIDTH bits (DEPTH a power of two).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_clear      : synchronous clear of pointers and count (wins over push/pop)
//   i_push       : write i_pushData (ignored when full)
//   i_pop        : drop head entry (ignored when empty)
//   o_head       : head entry, 0 when empty
//   o_count      : occupancy 0..DEPTH
//   o_full       : count == DEPTH
//   o_empty      : count == 0
// ---------------------------------------------------------------------------
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_INST_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_pushData,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_head,
  output logic [countWidth(DEPTH)-1:0]  o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = countWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_count  = r_count;
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_head   = o_empty ? '0 : r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Storage carries no reset; o_head masks stale contents while empty.
  always_ff @(posedge clk) begin
    if (w_doPush && !i_clear) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CW'(1);
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Walks a PC over a 1-cycle-latency instruction memory and buffers the
// returned words in a FIFO feeding the core. A request is only issued when
// the FIFO has room for it counting the one possibly in flight, so core
// stalls never overflow the buffer.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_start           : pulse, begins a run when idle
//   i_startPc         : first fetch address (sampled with i_start)
//   i_startLen        : instruction count (sampled with i_start)
//   i_flush           : abort run, discard buffered/in-flight words
//   o_imemReqValid    : memory read request this cycle
//   o_imemReqAddr     : memory read address (current PC)
//   i_imemRspValid    : memory response, one cycle after request
//   i_imemRspData     : memory response word
//   o_inst            : FIFO head to core (0 when empty)
//   o_instValid       : FIFO non-empty
//   i_instReady       : core accepts o_inst
//   o_busy            : not idle
//   o_done            : one-cycle pulse at end of a normal run
// ---------------------------------------------------------------------------
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PC_W   = DEF_PC_W,
  parameter int INST_W = DEF_INST_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [PC_W-1:0]   i_startPc,
  input  logic [LEN_W-1:0]  i_startLen,
  input  logic              i_flush,
  output logic              o_imemReqValid,
  output logic [PC_W-1:0]   o_imemReqAddr,
  input  logic              i_imemRspValid,
  input  logic [INST_W-1:0] i_imemRspData,
  output logic [INST_W-1:0] o_inst,
  output logic              o_instValid,
  input  logic              i_instReady,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = countWidth(DEPTH);

  fetchState_t       r_state;
  logic [PC_W-1:0]   r_pc;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_inflight;
  logic              r_done;

  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic [INST_W-1:0] w_head;
  logic [CW:0]       w_used;
  logic              w_req;
  logic              w_push;
  logic              w_pop;

  // Credit uses the registered count only; a same-cycle pop is not trusted.
  assign w_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req  = (r_state == RUN) && (r_remaining != '0) && (w_used < (CW + 1)'(DEPTH));

  // Responses without an outstanding request (e.g. right after a flush) are dropped.
  assign w_push = i_imemRspValid && r_inflight;
  assign w_pop  = !w_empty && i_instReady;

  assign o_imemReqValid = w_req;
  assign o_imemReqAddr  = r_pc;
  assign o_inst         = w_head;
  assign o_instValid    = !w_empty;
  assign o_busy         = (r_state != IDLE);
  assign o_done         = r_done;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (i_flush),
    .i_push     (w_push && !w_full),
    .i_pushData (i_imemRspData),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Fetch sequencer: flush has priority over everything, including start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else if (i_flush) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_req) begin
        r_inflight <= 1'b1;
      end else if (i_imemRspValid) begin
        r_inflight <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_startLen != '0) begin
              r_state     <= RUN;
              r_pc        <= i_startPc;
              r_remaining <= i_startLen;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_req) begin
            r_pc        <= r_pc + PC_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!r_inflight && (w_count == '0)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Front-end stage directly upstream of the 4-register pipeline core. It walks a PC over an instruction memory with a fixed 1-cycle read latency and buffers returned 8-bit instructions in a small FIFO. It presents them to the core on its inst/inst_valid/inst_ready handshake. Credit-based request issue guarantees the FIFO never overflows, so backpressure from the core's stalls is absorbed without loss.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PC_W, 8, PC and imem address width; PC wraps modulo 2^PC_W.
INST_W, 8, instruction width; must match the core's inst port.
LEN_W, 8, width of the program-length count.

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a fetch run; ignored unless IDLE.
start_pc  in  PC_W  first fetch address, sampled with start.
start_len  in  LEN_W  number of instructions to fetch, sampled with start.
flush  in  1  abort the run, discard buffered and in-flight instructions.
imem_req_valid  out  1  read request this cycle; always accepted.
imem_req_addr  out  PC_W  read address.
imem_rsp_valid  in  1  response valid, exactly 1 cycle after the request.
imem_rsp_data  in  INST_W  instruction word.
inst  out  INST_W  FIFO head, to core inst.
inst_valid  out  1  FIFO non-empty, to core inst_valid.
inst_ready  in  1  from core inst_ready.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at the end of a normal run.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE; pc=0; remaining=0; inflight=0.
  - FIFO read/write pointers and count = 0.
  - All outputs 0: inst=0, inst_valid=0, imem_req_valid=0, imem_req_addr=0, busy=0, done=0.
- States:
  - IDLE: start with start_len!=0 -> RUN; pc=start_pc, remaining=start_len. start with start_len==0 -> stay IDLE, done=1 next cycle.
  - RUN: issue requests. When the last request issues (remaining becomes 0) -> DRAIN.
  - DRAIN: wait until inflight==0 and count==0 -> IDLE, done=1 on the transition cycle's next edge (one cycle only).
- Request rule (RUN only): imem_req_valid = (remaining!=0) && (count + inflight < DEPTH).
  - The count term uses the registered count, not including a same-cycle pop (conservative).
  - On request: imem_req_addr=pc; pc<=pc+1 (wrap); remaining<=remaining-1; inflight<=1.
  - Back-to-back requests are allowed every cycle while credit exists.
- Response: imem_rsp_valid with inflight=1 pushes imem_rsp_data. inflight clears unless a new request issues the same cycle.
  - A response with inflight=0 is ignored.
- Output: inst=FIFO head (0 when empty); inst_valid=(count!=0). Pop when inst_valid && inst_ready.
  - Push/pop in the same cycle: count unchanged, both pointers advance.
  - Push when full cannot occur. The verifier asserts never (push && count==DEPTH).
  - inst and inst_valid are stable while inst_valid=1 and inst_ready=0.
- Flush, any state:
  - Next cycle: count=0, pointers=0, remaining=0, inflight=0, state=IDLE, no done pulse.
  - The response arriving the cycle after flush is dropped.
  - flush overrides start in the same cycle.
- FIFO order: instructions leave in ascending-address order with no duplication or loss. Total delivered per normal run = start_len.
- Latency: start at cycle t -> first request at t+1 -> response t+2 -> inst_valid at t+3.

Decomposition:
- Shared package fetch_pkg: state enum (IDLE, RUN, DRAIN); default DEPTH/PC_W/INST_W/LEN_W constants; OP_* opcode constants shared with the core for bench decoding.
- One natural sub-module: sync_fifo (DEPTH x INST_W, push/pop/count/full/empty, async active-high reset). The fetch FSM, credit logic and PC live in inst_fetch_unit.

Test Plan:
1. Reset mid-run: start_pc=0x10, start_len=8, assert rst at cycle 4 -> all outputs 0 immediately, busy=0, no done, no later inst_valid.
2. Streaming, inst_ready=1 always: start_pc=0x00, start_len=5, imem returns addr^0x40.
   - Required: inst sequence 0x40,0x41,0x42,0x43,0x44.
   - inst_valid first at t+3; done pulses once; 5 handshakes.
3. Backpressure: start_len=10, inst_ready=0 for 20 cycles, then 1.
   - Required: exactly DEPTH=4 requests, then imem_req_valid=0; count=4, no overflow.
   - After release: all 10 delivered in order.
4. PC wrap: start_pc=0xFE, start_len=4 -> imem_req_addr 0xFE,0xFF,0x00,0x01.
5. Flush: start_len=6, flush while a request is in flight and 2 entries are buffered.
   - Next cycle: inst_valid=0, busy=0.
   - The late rsp is not delivered, no done pulse; a new start then works normally.
6. start_len=0 -> no imem request, done=1 exactly one cycle, busy stays 0. start while RUN is ignored (pc unchanged).
